// File: rtl/trk_lpf_sched_pkg.sv
// Shared types and constants for the tracking loop-filter scheduler.
package trk_lpf_sched_pkg;

  // Width of discriminator values and FCW words.
  localparam int DW      = 32;
  // Default number of WAIT cycles before a filter transaction is abandoned.
  localparam int TMO_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/trk_lpf_sched_if.sv
// Start/done link between the scheduler (master) and the shared loop filter (slave).
//
// Handshake: lpf_start is a one-cycle pulse. lpf_sel and both lpf_*_disc are
// valid in the start cycle and stay stable until the filter answers. The filter
// answers with a one-cycle lpf_done pulse; lpf_car_fcw/lpf_prn_fcw are valid in
// that same cycle only. There is no back-pressure: the master never starts a new
// transaction before the previous one has completed or been abandoned, and a
// lpf_done arriving while no transaction is outstanding is ignored.
interface trk_lpf_sched_if #(
  parameter int SW = 2
);
  import trk_lpf_sched_pkg::*;

  logic          lpf_start;
  logic [SW-1:0] lpf_sel;
  logic [DW-1:0] lpf_pll_disc;
  logic [DW-1:0] lpf_dll_disc;
  logic          lpf_done;
  logic [DW-1:0] lpf_car_fcw;
  logic [DW-1:0] lpf_prn_fcw;

  modport master (
    output lpf_start, lpf_sel, lpf_pll_disc, lpf_dll_disc,
    input  lpf_done, lpf_car_fcw, lpf_prn_fcw
  );

  modport slave (
    input  lpf_start, lpf_sel, lpf_pll_disc, lpf_dll_disc,
    output lpf_done, lpf_car_fcw, lpf_prn_fcw
  );

endinterface

// File: rtl/trk_lpf_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pend_i at or above ptr_i, with wrap.
module trk_lpf_sched_rr_pick #(
  parameter int NCH = 4,
  parameter int SW  = 2
) (
  input  logic [NCH-1:0] pend_i,
  input  logic [SW-1:0]  ptr_i,
  output logic           vld_o,
  output logic [SW-1:0]  idx_o
);

  logic [SW-1:0] j;

  // Scan from the farthest candidate down so the nearest pending channel wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    j     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = SW'((int'(ptr_i) + k) % NCH);
      if (pend_i[j]) begin
        vld_o = 1'b1;
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/trk_lpf_sched.sv
// Shares one PLL/DLL loop-filter engine across NCH tracking channels: buffers
// each channel's discriminators at its dump, issues channels round-robin to the
// filter and writes the returned FCWs into per-channel NCO registers.
module trk_lpf_sched
  import trk_lpf_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SW  = 2,
  parameter int TMO = TMO_DEF
) (
  input  logic              rx_clk,
  input  logic              rx_rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*DW-1:0] ch_pll_disc,
  input  logic [NCH*DW-1:0] ch_dll_disc,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_ovf,
  input  logic [NCH-1:0]    ovf_clr,
  output logic [NCH*DW-1:0] ch_car_fcw,
  output logic [NCH*DW-1:0] ch_prn_fcw,
  trk_lpf_sched_if.master   lpf,
  output logic              tmo_err,
  output state_e            dbg_state_o
);

  localparam int CW = $clog2(TMO + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d, rr_q, rr_d, sel_nxt;
  logic [DW-1:0]     pll_q, pll_d, dll_q, dll_d;
  logic [DW-1:0]     car_res_q, car_res_d, prn_res_q, prn_res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [NCH-1:0]    pend_q, pend_d, ovf_q, ovf_d, issue_vec, ack_s;
  logic [NCH*DW-1:0] dbuf_pll_q, dbuf_pll_d, dbuf_dll_q, dbuf_dll_d;
  logic [NCH*DW-1:0] car_q, car_d, prn_q, prn_d;
  logic              pick_vld, start_s;
  logic [SW-1:0]     pick_idx;

  trk_lpf_sched_rr_pick #(.NCH(NCH), .SW(SW)) u_pick (
    .pend_i (pend_q),
    .ptr_i  (rr_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  assign sel_nxt = (int'(sel_q) == NCH - 1) ? '0 : sel_q + 1'b1;

  // Per-channel capture, pending/overrun bookkeeping and FCW write-back.
  always_comb begin
    issue_vec = '0;
    if (state_q == ST_ISSUE) issue_vec[sel_q] = 1'b1;
    // A request in the channel's own ISSUE cycle re-arms pend without overrun.
    pend_d     = ch_req | (pend_q & ~issue_vec);
    ovf_d      = (ch_req & pend_q & ~issue_vec) | (ovf_q & ~ovf_clr);
    dbuf_pll_d = dbuf_pll_q;
    dbuf_dll_d = dbuf_dll_q;
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[i]) begin
        dbuf_pll_d[i*DW +: DW] = ch_pll_disc[i*DW +: DW];
        dbuf_dll_d[i*DW +: DW] = ch_dll_disc[i*DW +: DW];
      end
    end
    car_d = car_q;
    prn_d = prn_q;
    if (state_q == ST_WB) begin
      car_d[int'(sel_q)*DW +: DW] = car_res_q;
      prn_d[int'(sel_q)*DW +: DW] = prn_res_q;
    end
  end

  // Scheduler FSM: next state, issue registers and start/ack pulses.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pll_d     = pll_q;
    dll_d     = dll_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    car_res_d = car_res_q;
    prn_res_d = prn_res_q;
    start_s   = 1'b0;
    ack_s     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          sel_d   = pick_idx;
          // A fresh dump on the granted channel this cycle supersedes the buffer.
          pll_d   = ch_req[pick_idx] ? ch_pll_disc[int'(pick_idx)*DW +: DW]
                                     : dbuf_pll_q[int'(pick_idx)*DW +: DW];
          dll_d   = ch_req[pick_idx] ? ch_dll_disc[int'(pick_idx)*DW +: DW]
                                     : dbuf_dll_q[int'(pick_idx)*DW +: DW];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_s       = 1'b1;
        ack_s[sel_q]  = 1'b1;
        cnt_d         = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (lpf.lpf_done) begin
          car_res_d = lpf.lpf_car_fcw;
          prn_res_d = lpf.lpf_prn_fcw;
          state_d   = ST_WB;
        end else if (cnt_q == CW'(TMO - 1)) begin
          // Filter never answered: keep old FCWs and move on to the next channel.
          tmo_d   = 1'b1;
          rr_d    = sel_nxt;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        rr_d    = sel_nxt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and filter-side registers.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      pll_q     <= '0;
      dll_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      car_res_q <= '0;
      prn_res_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pll_q     <= pll_d;
      dll_q     <= dll_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      car_res_q <= car_res_d;
      prn_res_q <= prn_res_d;
    end
  end

  // Channel-side registers: pending bits, overrun flags, buffers, FCW slots.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      pend_q     <= '0;
      ovf_q      <= '0;
      dbuf_pll_q <= '0;
      dbuf_dll_q <= '0;
      car_q      <= '0;
      prn_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      dbuf_pll_q <= dbuf_pll_d;
      dbuf_dll_q <= dbuf_dll_d;
      car_q      <= car_d;
      prn_q      <= prn_d;
    end
  end

  assign lpf.lpf_start    = start_s;
  assign lpf.lpf_sel      = sel_q;
  assign lpf.lpf_pll_disc = pll_q;
  assign lpf.lpf_dll_disc = dll_q;
  assign ch_ack           = ack_s;
  assign ch_ovf           = ovf_q;
  assign ch_car_fcw       = car_q;
  assign ch_prn_fcw       = prn_q;
  assign tmo_err          = tmo_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/trk_lpf_sched.md
# trk_lpf_sched

Time-multiplexes one tracking loop-filter engine (the PLL/DLL update datapath that turns discriminator outputs into carrier and code FCWs) across NCH tracking channels. Each channel raises a request at its integration dump with its PLL/DLL discriminator values. The scheduler buffers the values, grants channels round-robin, and runs a start/done handshake with the shared filter. It writes each result back into a per-channel carrier/code FCW register that feeds that channel's NCOs.

## Interface
- NCH, 4: number of tracking channels, 2..16
- SW, 2: channel-select width, ceil(log2(NCH))
- TMO, 255: max cycles to wait for lpf_done after lpf_start
- rx_clk  in  1  single clock
- rx_rst  in  1  asynchronous, active-high reset
- ch_req  in  NCH  per-channel one-cycle pulse at integration dump (prn sop)
- ch_pll_disc  in  NCH*32  per-channel PLL discriminator, signed; channel i at [32i+31:32i]
- ch_dll_disc  in  NCH*32  per-channel DLL discriminator, signed; same packing
- ch_ack  out  NCH  one-cycle pulse when channel i is issued to the filter
- ch_ovf  out  NCH  sticky: channel i re-requested while still pending
- ovf_clr  in  NCH  clears ch_ovf[i]
- ch_car_fcw  out  NCH*32  per-channel carrier FCW
- ch_prn_fcw  out  NCH*32  per-channel code FCW
- lpf_start  out  1  one-cycle filter start
- lpf_sel  out  SW  channel being filtered, held from start to done
- lpf_pll_disc  out  32  discriminator to filter, held from start to done
- lpf_dll_disc  out  32  same, DLL
- lpf_done  in  1  one-cycle pulse, filter results valid
- lpf_car_fcw  in  32  filter carrier FCW result
- lpf_prn_fcw  in  32  filter code FCW result
- tmo_err  out  1  sticky filter-timeout flag, cleared only by reset

## Operation
- Capture: when ch_req[i]=1, both discriminators are latched into the buffer for channel i and pend[i] is set.
- If pend[i] is already set and channel i is not being issued that cycle, the buffer is overwritten (latest values win) and ch_ovf[i] is set. When set and clear coincide, set wins.
- The FSM has four states: IDLE, ISSUE, WAIT, WB.
  - IDLE: if any pend bit is set, grant the first pending channel at or after rr_ptr, searching upward with wrap. Register lpf_sel and the two discriminators, then go to ISSUE.
  - ISSUE: lpf_start=1 and ch_ack[sel]=1 for this one cycle; clear pend[sel]; go to WAIT; reset the wait counter.
    - If ch_req[sel] arrives in the same cycle, pend[sel] stays set with the new values and ch_ovf is not set. The values already issued are unaffected.
  - WAIT: count cycles.
    - lpf_done: capture the results and go to WB.
    - Counter reaches TMO without lpf_done: set tmo_err, leave the FCWs unchanged, rr_ptr = sel+1, go to IDLE.
  - WB: write the captured FCWs to ch_car_fcw/ch_prn_fcw slot sel; rr_ptr = sel+1 mod NCH; go to IDLE.
- lpf_done outside WAIT is ignored.
- The result slices are taken verbatim; no arithmetic is done here.
- lpf_sel and lpf_*_disc stay stable from ISSUE through WAIT.

## Timing
- Reset values: all outputs 0; state IDLE; rr_ptr 0; pend 0. Reset mid-operation aborts the transaction and drops all pending requests.
- ch_req sampled at edge t: pend visible after t. If the FSM is idle, lpf_start and ch_ack are high in the cycle after edge t+1.
- lpf_done sampled at edge k: the FCW slot updates at edge k+1 (WB). The next lpf_start comes no earlier than 2 cycles after WB.
- Minimum grant period: 4 cycles plus the filter latency.
- With NCH simultaneous requests, all are served in ascending order from rr_ptr. No request is lost; only overwritten values are lost, and those are flagged by ch_ovf.

## Structure
- Shared package: FSM state enum (IDLE/ISSUE/WAIT/WB), 32-bit disc/FCW width constant, default TMO.
- Sub-module rr_pick: combinational round-robin priority picker taking pend and rr_ptr, returning a valid flag and an index.
- The per-channel buffers and FCW registers are flat vectors in the top level.

## Test plan
- Single request: ch_req[2] with pll=0x00001000, dll=0xFFFFF000. Filter model returns done 5 cycles after start with car=0x12345678, prn=0x0ABCDEF0.
  - lpf_start 2 cycles after req, lpf_sel=2, discs match.
  - Slot 2 updates exactly 1 cycle after done; other slots stay 0.
- Simultaneous ch_req=4'b1111 with rr_ptr=0: grants in order 0,1,2,3, one ack per grant, no ovf. A follow-up req on 1 and 3 is served 3 then 1 if rr_ptr=3.
- Overrun: ch_req[1] twice while channel 0 is busy, second with pll=0x7. Only one grant for ch1, it carries 0x7, ch_ovf[1]=1. ovf_clr[1] drops the flag.
- Request on the channel in its ISSUE cycle: the issued values are the old ones, pend stays set, a second grant follows, no ovf.
- Timeout: the model never asserts done. After TMO=255 cycles tmo_err=1, FCWs unchanged, and the next pending channel is granted.
- Reset asserted during WAIT: all outputs 0 asynchronously. After release no lpf_start appears until a new ch_req; a late lpf_done is ignored.
